// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer for the 8-bit computer.
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] memAddr,
  output logic       memReq,
  input  logic       memAck,
  input  logic [7:0] memData,
  output logic [1:0] aluCtrl,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [7:0] aluPc,
  input  logic [7:0] aluResult,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       halted,
  output logic       retire
);
  typedef enum logic [1:0] {FETCH, FETCH2, EXEC, HALT} state_t;
  state_t state, next;
  logic [7:0] ir, operand;
  logic [2:0] op, fetched_op;
  logic       hs;
  assign op         = ir[7:5];
  assign fetched_op = memData[7:5];
  assign hs         = memReq && memAck;
  assign memAddr    = pc;
  assign aluA       = acc;
  assign aluPc      = pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      FETCH:   if (hs) next = (fetched_op == 3'b011 || fetched_op == 3'b100) ? FETCH2 : EXEC;
      FETCH2:  if (hs) next = EXEC;
      EXEC:    next = (op == 3'b111) ? HALT : FETCH;
      default: next = HALT;
    endcase
  end
  // ALU controls only matter in EXEC; elsewhere they rest at zero.
  always_comb begin
    memReq  = !reset && (state == FETCH || state == FETCH2);
    retire  = state == EXEC;
    halted  = state == HALT;
    aluCtrl = !retire ? 2'b00 :
              op == 3'b001 ? 2'b01 :
              op == 3'b010 ? 2'b11 :
              op == 3'b011 ? 2'b10 : 2'b00;
    aluB    = !retire ? 8'h00 :
              op <= 3'b010 ? {3'b000, ir[4:0]} :
              op == 3'b011 ? operand : 8'h00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc      <= RESET_PC;
      acc     <= 8'h00;
      ir      <= 8'h00;
      operand <= 8'h00;
    end else begin
      if (hs) begin
        pc <= pc + 8'd1;
        if (state == FETCH) ir <= memData;
        else operand <= memData;
      end
      if (state == EXEC)
        case (op)
          3'b000, 3'b001, 3'b010: acc <= aluResult;
          3'b011:                 pc  <= aluResult;
          3'b100:                 acc <= operand;
          default:                ;
        endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random and directed programs checked against an instruction-level model.
module tb_cpu_sequencer;
  logic clk = 0, reset = 1, reset1 = 1;
  logic [7:0] memAddr, memData, aluA, aluB, aluPc, aluResult, acc, pc;
  logic [7:0] memAddr1, memData1, aluA1, aluB1, aluPc1, aluResult1, acc1, pc1;
  logic [1:0] aluCtrl, aluCtrl1;
  logic memReq, memAck = 0, halted, retire;
  logic memReq1, memAck1, halted1, retire1;
  logic [7:0] mem [256];
  logic [7:0] mem1 [256];
  int checks = 0, failures = 0, cyc = 0, wait_n = 0, wcnt = 0, last_ret = 0;
  bit noise = 0;
  logic [7:0] m_pc, m_acc;

  cpu_sequencer u0 (.clk(clk), .reset(reset), .memAddr(memAddr), .memReq(memReq), .memAck(memAck),
    .memData(memData), .aluCtrl(aluCtrl), .aluA(aluA), .aluB(aluB), .aluPc(aluPc),
    .aluResult(aluResult), .acc(acc), .pc(pc), .halted(halted), .retire(retire));
  cpu_sequencer #(.RESET_PC(8'hFF)) u1 (.clk(clk), .reset(reset1), .memAddr(memAddr1),
    .memReq(memReq1), .memAck(memAck1), .memData(memData1), .aluCtrl(aluCtrl1), .aluA(aluA1),
    .aluB(aluB1), .aluPc(aluPc1), .aluResult(aluResult1), .acc(acc1), .pc(pc1),
    .halted(halted1), .retire(retire1));

  function automatic logic [7:0] alu(input logic [1:0] c, input logic [7:0] a, b, p);
    return c == 2'd0 ? a + b : c == 2'd1 ? ~(a & b) : c == 2'd2 ? (a == 8'h00 ? b : p) : {7'b0, a < b};
  endfunction

  assign aluResult  = alu(aluCtrl, aluA, aluB, aluPc);
  assign aluResult1 = alu(aluCtrl1, aluA1, aluB1, aluPc1);
  assign memData    = mem[memAddr];
  assign memData1   = mem1[memAddr1];
  assign memAck1    = memReq1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after wait_n idle cycles, random stale acks when not requested.
  initial forever begin
    @(negedge clk);
    if (memReq) begin
      if (wcnt >= wait_n) begin memAck = 1; wcnt = 0; end
      else begin memAck = 0; wcnt++; end
    end else begin
      memAck = noise ? 1'($urandom) : 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [39:0] p);
    foreach (mem[i]) mem[i] = 8'hE0;
    for (int i = 0; i < 5; i++) mem[i] = p[39-8*i -: 8];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("rst_req", memReq, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_aluctrl", aluCtrl, 0);
    chk("rst_alub", aluB, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    last_ret = cyc - 1;
    m_pc = 8'h00;
    m_acc = 8'h00;
  endtask

  task automatic run_retires(input int max);
    logic [7:0] ir, opnd, imm, nxt;
    logic [2:0] op;
    logic [1:0] e_ctrl;
    logic [7:0] e_b;
    bit two;
    int t;
    for (int n = 0; n < max; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!retire && t < 200);
      if (!retire) begin chk("retire_timeout", 0, 1); return; end
      ir = mem[m_pc];
      op = ir[7:5];
      imm = {3'b000, ir[4:0]};
      nxt = m_pc + 8'd1;
      opnd = mem[nxt];
      two = op == 3'd3 || op == 3'd4;
      e_ctrl = op == 3'd1 ? 2'd1 : op == 3'd2 ? 2'd3 : op == 3'd3 ? 2'd2 : 2'd0;
      e_b = op <= 3'd2 ? imm : op == 3'd3 ? opnd : 8'h00;
      chk("spacing", cyc - last_ret, (wait_n + 1) * (two ? 2 : 1) + 1);
      last_ret = cyc;
      chk("alu_ctrl", aluCtrl, e_ctrl);
      chk("alu_b", aluB, e_b);
      m_pc = m_pc + (two ? 8'd2 : 8'd1);
      case (op)
        3'd0: m_acc = m_acc + imm;
        3'd1: m_acc = ~(m_acc & imm);
        3'd2: m_acc = (m_acc < imm) ? 8'd1 : 8'd0;
        3'd3: if (m_acc == 8'h00) m_pc = opnd;
        3'd4: m_acc = opnd;
        default: ;
      endcase
      @(posedge clk);
      #1;
      chk("acc", acc, m_acc);
      chk("pc", pc, m_pc);
      chk("halted", halted, op == 3'd7);
      if (op == 3'd7) begin
        repeat (3) begin
          @(negedge clk);
          chk("halt_req", memReq, 0);
          chk("halt_pc", pc, m_pc);
        end
        return;
      end
    end
  endtask

  initial begin
    int t;
    foreach (mem1[i]) mem1[i] = 8'hE0;
    mem1[8'hFF] = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_rst_pc", pc1, 8'hFF);
    reset1 = 0;
    t = 0;
    while (!halted1 && t < 50) begin @(negedge clk); t++; end
    chk("wrap_halted", halted1, 1);
    chk("wrap_pc", pc1, 8'h01);
    chk("wrap_acc", acc1, 8'h01);

    load(40'h80_05_03_E0_E0);
    do_reset(); run_retires(10);
    chk("p1_acc", acc, 8'h08);
    chk("p1_pc", pc, 8'h04);
    wait_n = 3;
    do_reset(); run_retires(10);
    chk("p1w_acc", acc, 8'h08);
    wait_n = 0;
    load(40'h80_00_60_20_E0);
    do_reset(); run_retires(10);
    chk("bz_taken_pc", pc, 8'h21);
    load(40'h80_01_60_20_E0);
    do_reset(); run_retires(10);
    chk("bz_fall_pc", pc, 8'h05);
    load(40'h80_03_45_40_E0);
    do_reset(); run_retires(10);
    chk("slt_acc", acc, 8'h00);
    load(40'h80_F0_3F_E0_E0);
    do_reset(); run_retires(10);
    chk("nand_acc", acc, 8'hEF);

    load(40'h80_05_03_E0_E0);
    wait_n = 5;
    noise = 1;
    do_reset();
    t = 0;
    while (!(memReq && memAddr == 8'h01) && t < 100) begin @(negedge clk); t++; end
    chk("reach_fetch2", memAddr, 8'h01);
    do_reset();
    run_retires(10);
    chk("abort_acc", acc, 8'h08);

    repeat (4) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      wait_n = $urandom_range(0, 3);
      do_reset();
      run_retires(30);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit computer. It owns the PC, instruction register, operand register and accumulator. It fetches instruction bytes from program memory over a req/ack handshake, drives the combinational ALU's operand and control inputs, and registers the ALU result into ACC or PC. It sits directly upstream of the ALU, supplying its inputs, and directly downstream of it, consuming its result.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
memAddr  output  8  program memory byte address; equals pc.
memReq  output  1  fetch request; held until acknowledged.
memAck  input  1  memory has valid memData this cycle.
memData  input  8  fetched byte.
aluCtrl  output  2  ALU function: 00 add, 01 nand, 10 branch select, 11 set-less-than.
aluA  output  8  ALU accumulator operand; always equals acc.
aluB  output  8  ALU second operand.
aluPc  output  8  ALU pc input; always equals pc.
aluResult  input  8  combinational ALU output.
acc  output  8  accumulator contents.
pc  output  8  program counter.
halted  output  1  high in HALT state.
retire  output  1  one-cycle pulse in each EXEC cycle.

Behaviour:
- ISA, instruction byte IR: op = IR[7:5], imm = {3'b0, IR[4:0]}.
  - 000 ADD: acc <= acc + imm (ALU 00).
  - 001 NAND: acc <= ~(acc & imm) (ALU 01).
  - 010 SLT: acc <= (acc < imm) ? 1 : 0, unsigned (ALU 11).
  - 011 BZ: two-byte instruction; operand byte is the target. ALU 10 with aluB = target; pc <= aluResult. Result is target if acc == 0, else the fall-through pc.
  - 100 LDI: two-byte instruction; acc <= operand byte. ALU not used.
  - 101, 110: NOP.
  - 111: HALT.
- States: FETCH, FETCH2, EXEC, HALT.
- Reset (async): state = FETCH, pc = RESET_PC, acc = 0, IR = 0, operand = 0. halted = 0, retire = 0, aluCtrl = 00, aluB = 0.
- memReq = 1 only in FETCH and FETCH2, and is forced 0 while reset is high.
- FETCH:
  - Hold memReq until memReq && memAck.
  - On that edge: IR <= memData, pc <= pc + 1.
  - Next state is FETCH2 if op is 011 or 100, otherwise EXEC.
  - memAck may be high in the same cycle memReq rises (zero wait) or any number of cycles later. memAck outside FETCH/FETCH2 is ignored.
- FETCH2: same handshake as FETCH. On acknowledge: operand <= memData, pc <= pc + 1, next state EXEC.
- EXEC: exactly one cycle.
  - aluCtrl and aluB are driven combinationally from IR and operand.
  - aluB = imm for ADD/NAND/SLT, operand for BZ, 0 otherwise.
  - aluCtrl = 00 for LDI/NOP/HALT.
  - On the clock edge: the register update listed in the ISA above; next state FETCH, or HALT for op 111.
  - retire = 1 during EXEC.
- HALT: terminal. No memReq, pc and acc frozen, halted = 1. Only reset exits.
- Arithmetic: all 8-bit modulo 256.
  - ADD carry is discarded.
  - pc increment wraps 8'hFF -> 8'h00, including a two-byte instruction that straddles 0xFF.
- Latency: one-byte instruction = ack cycle + 1 EXEC cycle (2 cycles with zero-wait memory). Two-byte instruction = 3 cycles.
- Reset mid-operation: an outstanding request is abandoned. The next post-reset fetch is from RESET_PC, and a late memAck is ignored unless state is FETCH and memReq is high.
- BZ timing: BZ samples acc as updated by the previous instruction's EXEC (registered value). Writing the branch target into pc overrides the sequential increment.

Test Plan:
- Zero-wait memory, program LDI 0x05; ADD 3; HALT -> acc = 0x08 after 2nd retire; halted = 1; pc = 0x04; memReq low thereafter.
- LDI 0x00; BZ 0x20 -> pc = 0x20 after BZ EXEC. Repeat with LDI 0x01 -> pc = 0x04 (fall-through).
- acc = 0x03; SLT 5 -> acc = 0x01. Then SLT 0 -> acc = 0x00. Separately, acc = 0xF0; NAND 0x1F -> acc = 0xEF.
- memAck delayed 3 cycles on each fetch -> memReq and memAddr stable during the wait; same final acc as the zero-wait run; retire count matches instruction count.
- RESET_PC = 0xFF, byte 0xFF = ADD 1, byte 0x00 = HALT -> pc wraps to 0x00, HALT fetched, final pc = 0x01.
- Assert reset while memReq is high and waiting in FETCH2 -> all outputs at reset values immediately. After release, fetch from RESET_PC. A stale memAck pulse during reset has no effect.
